// File: rtl/ddr3_arb_pkg.sv
// Shared types and helpers for the DDR3 Wishbone arbiter.
// Build option: DDR3_ARB_FIXED_PRIORITY_EN selects fixed-priority picking.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ddr3_arb_rr_pick.sv
// Combinational next-requester picker: round-robin after i_last,
// or lowest index when DDR3_ARB_FIXED_PRIORITY_EN is defined.
module ddr3_arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

`ifdef DDR3_ARB_FIXED_PRIORITY_EN
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = IW'(k);
            end
        end
    end
`else
    always_comb begin : p_pick
        int c;
        o_valid = 1'b0;
        o_idx   = '0;
        c       = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(i_last) + k) % N;
            if (!o_valid && i_req[c]) begin
                o_valid = 1'b1;
                o_idx   = IW'(c);
            end
        end
    end
`endif

endmodule

// File: rtl/ddr3_wb_arbiter.sv
// Cyc-locked arbiter sharing the DDR3 controller Wishbone port.
// Build option: DDR3_ARB_FIXED_PRIORITY_EN (see ddr3_arb_rr_pick).
module ddr3_wb_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int WB_ADDR_BITS    = 24,
    parameter int WB_DATA_BITS    = 512,
    parameter int AUX_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 16,
    parameter int OPT_BUS_ABORT   = 1
) (
    input  logic                                   i_controller_clk,
    input  logic                                   i_rst,
    input  logic [NUM_MASTERS-1:0]                 i_m_cyc,
    input  logic [NUM_MASTERS-1:0]                 i_m_stb,
    input  logic [NUM_MASTERS-1:0]                 i_m_we,
    input  logic [NUM_MASTERS*WB_ADDR_BITS-1:0]    i_m_addr,
    input  logic [NUM_MASTERS*WB_DATA_BITS-1:0]    i_m_data,
    input  logic [NUM_MASTERS*WB_DATA_BITS/8-1:0]  i_m_sel,
    input  logic [NUM_MASTERS*AUX_WIDTH-1:0]       i_m_aux,
    output logic [NUM_MASTERS-1:0]                 o_m_stall,
    output logic [NUM_MASTERS-1:0]                 o_m_ack,
    output logic [WB_DATA_BITS-1:0]                o_m_data,
    output logic [AUX_WIDTH-1:0]                   o_m_aux,
    output logic                                   o_wb_cyc,
    output logic                                   o_wb_stb,
    output logic                                   o_wb_we,
    output logic [WB_ADDR_BITS-1:0]                o_wb_addr,
    output logic [WB_DATA_BITS-1:0]                o_wb_data,
    output logic [WB_DATA_BITS/8-1:0]              o_wb_sel,
    output logic [AUX_WIDTH-1:0]                   o_wb_aux,
    input  logic                                   i_wb_stall,
    input  logic                                   i_wb_ack,
    input  logic [WB_DATA_BITS-1:0]                i_wb_data,
    input  logic [AUX_WIDTH-1:0]                   i_wb_aux,
    output logic [$clog2(NUM_MASTERS)-1:0]         o_owner
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = WB_DATA_BITS / 8;
    localparam int CW = cnt_width(MAX_OUTSTANDING);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_pick;
    logic          w_pick_valid;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_ack_ok;
    int            w_own;

    ddr3_arb_rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .i_req   (i_m_cyc),
        .i_last  (r_owner),
        .o_idx   (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_own     = int'(r_owner);
    assign w_full    = (r_count == CW'(MAX_OUTSTANDING));
    assign w_own_cyc = i_m_cyc[r_owner];
    assign w_own_stb = i_m_stb[r_owner];
    // Acks with nothing outstanding belong to an aborted cycle.
    assign w_ack_ok  = i_wb_ack && (r_count != '0);
    assign o_m_data  = i_wb_data;
    assign o_m_aux   = i_wb_aux;
    assign o_owner   = r_owner;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        o_wb_cyc    = 1'b0;
        o_wb_stb    = 1'b0;
        o_wb_we     = 1'b0;
        o_wb_addr   = '0;
        o_wb_data   = '0;
        o_wb_sel    = '0;
        o_wb_aux    = '0;
        o_m_stall   = '1;
        o_m_ack     = '0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) w_state_nxt = GRANT;
            end
            GRANT: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = w_own_cyc & w_own_stb & ~w_full;
                o_wb_we   = i_m_we[r_owner];
                o_wb_addr = i_m_addr[slice_lo(w_own, WB_ADDR_BITS) +: WB_ADDR_BITS];
                o_wb_data = i_m_data[slice_lo(w_own, WB_DATA_BITS) +: WB_DATA_BITS];
                o_wb_sel  = i_m_sel[slice_lo(w_own, SW) +: SW];
                o_wb_aux  = i_m_aux[slice_lo(w_own, AUX_WIDTH) +: AUX_WIDTH];
                o_m_stall[r_owner] = i_wb_stall | w_full;
                o_m_ack[r_owner]   = w_ack_ok & w_own_cyc;
                w_count_nxt = r_count + CW'(o_wb_stb & ~i_wb_stall)
                            - CW'(w_ack_ok);
                if (!w_own_cyc) begin
                    if (OPT_BUS_ABORT != 0) begin
                        o_wb_cyc    = 1'b0;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = (w_count_nxt != '0) ? DRAIN : IDLE;
                    end
                end
            end
            DRAIN: begin
                o_wb_cyc    = 1'b1;
                w_count_nxt = r_count - CW'(w_ack_ok);
                if (w_count_nxt == '0) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_controller_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_owner <= IW'(NUM_MASTERS - 1);
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (r_state == IDLE && w_pick_valid) r_owner <= w_pick;
        end
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed bench for ddr3_wb_arbiter: one abort-mode and one drain-mode
// instance share stimulus so both release policies are checked side by side.
module tb_ddr3_wb_arbiter;

    localparam int AW = 24;
    localparam int DW = 512;
    localparam int XW = 16;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      m_cyc, m_stb, m_we;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_data;
    logic [2*SW-1:0] m_sel;
    logic [2*XW-1:0] m_aux;
    logic            wb_stall, wb_ack;
    logic [DW-1:0]   wb_data;
    logic [XW-1:0]   wb_aux;

    logic [1:0]    a_m_stall, a_m_ack, d_m_stall, d_m_ack;
    logic [DW-1:0] a_m_data, d_m_data, a_wb_data, d_wb_data;
    logic [XW-1:0] a_m_aux, d_m_aux, a_wb_aux, d_wb_aux;
    logic          a_wb_cyc, a_wb_stb, a_wb_we, d_wb_cyc, d_wb_stb, d_wb_we;
    logic [AW-1:0] a_wb_addr, d_wb_addr;
    logic [SW-1:0] a_wb_sel, d_wb_sel;
    logic [0:0]    a_owner, d_owner;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ddr3_wb_arbiter #(.OPT_BUS_ABORT(1)) u_a (
        .i_controller_clk(clk), .i_rst(rst),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_addr(m_addr), .i_m_data(m_data), .i_m_sel(m_sel),
        .i_m_aux(m_aux), .o_m_stall(a_m_stall), .o_m_ack(a_m_ack),
        .o_m_data(a_m_data), .o_m_aux(a_m_aux),
        .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb), .o_wb_we(a_wb_we),
        .o_wb_addr(a_wb_addr), .o_wb_data(a_wb_data),
        .o_wb_sel(a_wb_sel), .o_wb_aux(a_wb_aux),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_data(wb_data), .i_wb_aux(wb_aux), .o_owner(a_owner)
    );

    ddr3_wb_arbiter #(.OPT_BUS_ABORT(0)) u_d (
        .i_controller_clk(clk), .i_rst(rst),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_addr(m_addr), .i_m_data(m_data), .i_m_sel(m_sel),
        .i_m_aux(m_aux), .o_m_stall(d_m_stall), .o_m_ack(d_m_ack),
        .o_m_data(d_m_data), .o_m_aux(d_m_aux),
        .o_wb_cyc(d_wb_cyc), .o_wb_stb(d_wb_stb), .o_wb_we(d_wb_we),
        .o_wb_addr(d_wb_addr), .o_wb_data(d_wb_data),
        .o_wb_sel(d_wb_sel), .o_wb_aux(d_wb_aux),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
        .i_wb_data(wb_data), .i_wb_aux(wb_aux), .o_owner(d_owner)
    );

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        wb_ack = 1'b0; wb_stall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0 || a_wb_stb !== 1'b0)
            $display("FAIL reset_cycstb got %b%b want 00", a_wb_cyc, a_wb_stb);
        else n_pass++;
        n_total++;
        if (a_m_stall !== 2'b11 || a_m_ack !== 2'b00)
            $display("FAIL reset_stall_ack got %b/%b want 11/00", a_m_stall, a_m_ack);
        else n_pass++;
        n_total++;
        if (a_owner !== 1'b1 || a_wb_addr !== '0 || u_a.r_count !== 5'd0)
            $display("FAIL reset_state got owner=%b addr=%h cnt=%0d want 1/0/0",
                     a_owner, a_wb_addr, u_a.r_count);
        else n_pass++;
    endtask

    task automatic test_write_burst;
        logic e_stb, e_ack;
        do_reset;
        m_cyc = 2'b01; m_we = 2'b01;
        for (int c = 0; c < 10; c++) begin
            m_stb[0] = (c <= 4);
            wb_ack = (c >= 4 && c <= 7);
            #1;
            e_stb = (c >= 1 && c <= 4);
            e_ack = (c >= 4 && c <= 7);
            n_total++;
            if (a_wb_stb !== e_stb)
                $display("FAIL burst_stb c=%0d got %b want %b", c, a_wb_stb, e_stb);
            else n_pass++;
            n_total++;
            if (a_m_ack[0] !== e_ack)
                $display("FAIL burst_ack c=%0d got %b want %b", c, a_m_ack[0], e_ack);
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if (a_wb_addr !== 24'hA0A000 || a_wb_we !== 1'b1)
                    $display("FAIL burst_addr got %h/%b want a0a000/1", a_wb_addr, a_wb_we);
                else n_pass++;
            end
            nxt;
        end
        wb_ack = 1'b0;
        n_total++;
        if (u_a.r_count !== 5'd0)
            $display("FAIL burst_count got %0d want 0", u_a.r_count);
        else n_pass++;
        m_cyc = 2'b00;
        nxt;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0)
            $display("FAIL burst_release got %b want 0", a_wb_cyc);
        else n_pass++;
    endtask

    task automatic test_arbitration;
        logic e_own;
`ifdef DDR3_ARB_FIXED_PRIORITY_EN
        e_own = 1'b0;
`else
        e_own = 1'b1;
`endif
        do_reset;
        m_cyc = 2'b11;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0)
            $display("FAIL arb_latency got cyc=%b want 0", a_wb_cyc);
        else n_pass++;
        nxt;
        #1;
        n_total++;
        if (a_owner !== 1'b0 || a_wb_cyc !== 1'b1 || a_m_stall[1] !== 1'b1)
            $display("FAIL arb_first got owner=%b cyc=%b stall1=%b want 0/1/1",
                     a_owner, a_wb_cyc, a_m_stall[1]);
        else n_pass++;
        m_cyc = 2'b10;
        nxt;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0)
            $display("FAIL arb_idle_gap got cyc=%b want 0", a_wb_cyc);
        else n_pass++;
        m_cyc = 2'b11;
        nxt;
        #1;
        n_total++;
        if (a_owner !== e_own || a_wb_cyc !== 1'b1)
            $display("FAIL arb_second got owner=%b cyc=%b want %b/1",
                     a_owner, a_wb_cyc, e_own);
        else n_pass++;
        n_total++;
        if (a_wb_addr !== (e_own ? 24'hB0B001 : 24'hA0A000))
            $display("FAIL arb_addr_mux got %h want owner %b address", a_wb_addr, e_own);
        else n_pass++;
        m_cyc = e_own ? 2'b01 : 2'b10;
        nxt;
        m_cyc = 2'b11;
        nxt;
        #1;
        n_total++;
        if (a_owner !== 1'b0 || a_wb_cyc !== 1'b1)
            $display("FAIL arb_third got owner=%b cyc=%b want 0/1", a_owner, a_wb_cyc);
        else n_pass++;
    endtask

    task automatic test_full;
        int n;
        do_reset;
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
        n = 0;
        for (int c = 0; c <= 16; c++) begin
            #1;
            if (a_wb_stb && !a_m_stall[0]) n++;
            nxt;
        end
        n_total++;
        if (n !== 16)
            $display("FAIL full_accepts got %0d want 16", n);
        else n_pass++;
        #1;
        n_total++;
        if (a_m_stall[0] !== 1'b1 || a_wb_stb !== 1'b0)
            $display("FAIL full_stall got stall=%b stb=%b want 1/0", a_m_stall[0], a_wb_stb);
        else n_pass++;
        wb_ack = 1'b1;
        #1;
        n_total++;
        if (a_m_ack[0] !== 1'b1)
            $display("FAIL full_ack got %b want 1", a_m_ack[0]);
        else n_pass++;
        nxt;
        wb_ack = 1'b0;
        #1;
        n_total++;
        if (a_wb_stb !== 1'b1 || a_m_stall[0] !== 1'b0)
            $display("FAIL full_reopen got stb=%b stall=%b want 1/0", a_wb_stb, a_m_stall[0]);
        else n_pass++;
        nxt;
        #1;
        n_total++;
        if (a_wb_stb !== 1'b0 || a_m_stall[0] !== 1'b1)
            $display("FAIL full_again got stb=%b stall=%b want 0/1", a_wb_stb, a_m_stall[0]);
        else n_pass++;
        m_cyc = 2'b00; m_stb = 2'b00;
        nxt;
    endtask

    task automatic test_abort_drain;
        do_reset;
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
        for (int c = 0; c < 4; c++) nxt;
        m_stb = 2'b00; m_cyc = 2'b11;
        nxt;
        m_cyc = 2'b10;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0 || d_wb_cyc !== 1'b1)
            $display("FAIL abort_drop got a=%b d=%b want 0/1", a_wb_cyc, d_wb_cyc);
        else n_pass++;
        nxt;
        wb_ack = 1'b1;
        #1;
        n_total++;
        if (u_a.r_count !== 5'd0 || a_wb_cyc !== 1'b0 || a_m_ack !== 2'b00)
            $display("FAIL abort_cleared got cnt=%0d cyc=%b ack=%b want 0/0/00",
                     u_a.r_count, a_wb_cyc, a_m_ack);
        else n_pass++;
        n_total++;
        if (d_wb_cyc !== 1'b1 || d_m_ack !== 2'b00 || d_m_stall !== 2'b11)
            $display("FAIL drain_1 got cyc=%b ack=%b stall=%b want 1/00/11",
                     d_wb_cyc, d_m_ack, d_m_stall);
        else n_pass++;
        nxt;
        #1;
        n_total++;
        if (a_owner !== 1'b1 || a_wb_cyc !== 1'b1 || a_m_ack !== 2'b00)
            $display("FAIL abort_next got owner=%b cyc=%b ack=%b want 1/1/00",
                     a_owner, a_wb_cyc, a_m_ack);
        else n_pass++;
        n_total++;
        if (d_wb_cyc !== 1'b1 || d_m_ack !== 2'b00)
            $display("FAIL drain_2 got cyc=%b ack=%b want 1/00", d_wb_cyc, d_m_ack);
        else n_pass++;
        nxt;
        #1;
        n_total++;
        if (d_wb_cyc !== 1'b1 || d_m_ack !== 2'b00 || d_wb_stb !== 1'b0)
            $display("FAIL drain_3 got cyc=%b ack=%b stb=%b want 1/00/0",
                     d_wb_cyc, d_m_ack, d_wb_stb);
        else n_pass++;
        nxt;
        wb_ack = 1'b0;
        #1;
        n_total++;
        if (d_wb_cyc !== 1'b0 || u_d.r_count !== 5'd0)
            $display("FAIL drain_idle got cyc=%b cnt=%0d want 0/0", d_wb_cyc, u_d.r_count);
        else n_pass++;
        nxt;
        #1;
        n_total++;
        if (d_owner !== 1'b1 || d_wb_cyc !== 1'b1)
            $display("FAIL drain_next got owner=%b cyc=%b want 1/1", d_owner, d_wb_cyc);
        else n_pass++;
        m_cyc = 2'b00;
        nxt;
    endtask

    task automatic test_async_reset;
        do_reset;
        m_cyc = 2'b01; m_stb = 2'b01;
        for (int c = 0; c < 6; c++) nxt;
        m_stb = 2'b00;
        #1;
        n_total++;
        if (u_a.r_count !== 5'd5)
            $display("FAIL areset_pre got cnt=%0d want 5", u_a.r_count);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (a_wb_cyc !== 1'b0 || a_m_stall !== 2'b11 || u_a.r_count !== 5'd0 || a_owner !== 1'b1)
            $display("FAIL areset_mid got cyc=%b stall=%b cnt=%0d owner=%b want 0/11/0/1",
                     a_wb_cyc, a_m_stall, u_a.r_count, a_owner);
        else n_pass++;
        m_cyc = 2'b00;
        #1;
        rst = 1'b0;
        nxt;
        wb_ack = 1'b1;
        #1;
        n_total++;
        if (a_m_ack !== 2'b00)
            $display("FAIL areset_stray got ack=%b want 00", a_m_ack);
        else n_pass++;
        nxt;
        wb_ack = 1'b0;
        #1;
        n_total++;
        if (u_a.r_count !== 5'd0 || a_wb_cyc !== 1'b0)
            $display("FAIL areset_after got cnt=%0d cyc=%b want 0/0", u_a.r_count, a_wb_cyc);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        m_addr = {24'hB0B001, 24'hA0A000};
        m_data = {{16{32'h1111_2222}}, {16{32'h3333_4444}}};
        m_sel = '1;
        m_aux = {16'h00B1, 16'h00A0};
        wb_data = {16{32'hDEAD_BEEF}};
        wb_aux = 16'h5A5A;
        test_reset;
        test_write_burst;
        test_arbitration;
        test_full;
        test_abort_drain;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 time units");
        $fatal(1);
    end

endmodule
